pmem_arbiter: RTL and testbench

Parametrised physical-memory arbiter: it lets NUM_PORTS cache-side requesters share one cacheline-wide physical memory port. Requesters are split I/D caches or an L2 fill path. It grants round-robin, latches the winning request, runs a single read or write on the pmem interface, and returns the response to the winner only. It sits between the caches and the pmem_* pins of the top level, and generalises the single-cache direct connection to N channels.

---
 rtl/pmem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_pmem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Round-robin arbiter that lets NUM_PORTS cache-side requesters share one
//   cacheline-wide physical memory port. One transaction runs at a time:
//   IDLE picks a winner and latches its request, BUSY drives the pmem pins
//   from that latch until pmem_resp, and DONE returns the line to the winner.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_read/req_write        per-port request flags (write wins if both set)
//   req_address/req_wdata     per-port address/line, port i at [i*W +: W]
//   req_resp                  one-cycle completion pulse to the winner only
//   req_rdata                 read line, broadcast, valid while req_resp set
//   pmem_read/pmem_write      memory strobes, registered, never both high
//   pmem_address/pmem_wdata   latched request towards memory
//   pmem_resp/pmem_rdata      memory completion and read line
//   busy                      high in BUSY and DONE
//   grant                     index of current or last granted port
//   dbg_state_o               current FSM state for external checkers
//
// Handshake: a requester raises req_read/req_write with address/wdata and
// holds them until it sees its req_resp bit; it drops the request on the
// edge that ends the req_resp cycle. Memory sees a strobe held high until it
// answers with a single-cycle pmem_resp; pmem_resp outside BUSY is ignored.
module pmem_arbiter #(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128,
   localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            req_read,
   input  logic [NUM_PORTS-1:0]            req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
   input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata,
   output logic [NUM_PORTS-1:0]            req_resp,
   output logic [LINE_WIDTH-1:0]           req_rdata,
   output logic                            pmem_read,
   output logic                            pmem_write,
   output logic [ADDR_WIDTH-1:0]           pmem_address,
   output logic [LINE_WIDTH-1:0]           pmem_wdata,
   input  logic                            pmem_resp,
   input  logic [LINE_WIDTH-1:0]           pmem_rdata,
   output logic                            busy,
   output logic [GW-1:0]                   grant,
   output logic [1:0]                      dbg_state_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // After reset the "last" grant is the highest port so port 0 wins first.
   localparam logic [GW-1:0] LAST_RESET = GW'(NUM_PORTS - 1);

   logic [1:0]            state_q, state_d;
   logic [GW-1:0]         grant_q, grant_d;
   logic [GW-1:0]         last_grant_q, last_grant_d;
   logic                  pmem_read_q, pmem_read_d;
   logic                  pmem_write_q, pmem_write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
   logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
   logic [NUM_PORTS-1:0]  resp_q, resp_d;

   logic [NUM_PORTS-1:0]  pending;
   logic                  any_hi, any_lo;
   logic [GW-1:0]         pick_hi, pick_lo, pick;
   logic                  sel_write;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [LINE_WIDTH-1:0] sel_wdata;

   assign pending = req_read | req_write;

   // Circular search starting after last_grant: the lowest pending index
   // above last_grant wins; if there is none, wrap to the lowest pending
   // index overall. Scanning downwards leaves the lowest match in each pick.
   always_comb begin
      any_hi  = 1'b0;
      any_lo  = 1'b0;
      pick_hi = '0;
      pick_lo = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (pending[i]) begin
            any_lo  = 1'b1;
            pick_lo = GW'(i);
         end
         if (pending[i] && (GW'(i) > last_grant_q)) begin
            any_hi  = 1'b1;
            pick_hi = GW'(i);
         end
      end
      pick = any_hi ? pick_hi : pick_lo;
   end

   // Request fields of the chosen port.
   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (GW'(i) == pick) begin
            sel_write = req_write[i];
            sel_addr  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      pmem_read_d  = pmem_read_q;
      pmem_write_d = pmem_write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      resp_d       = '0;
      case (state_q)
         ST_IDLE: begin
            if (any_lo) begin
               state_d      = ST_BUSY;
               grant_d      = pick;
               last_grant_d = pick;
               addr_d       = sel_addr;
               wdata_d      = sel_wdata;
               pmem_write_d = sel_write;
               pmem_read_d  = !sel_write;
            end
         end
         ST_BUSY: begin
            if (pmem_resp) begin
               state_d      = ST_DONE;
               rdata_d      = pmem_rdata;
               pmem_read_d  = 1'b0;
               pmem_write_d = 1'b0;
               for (int i = 0; i < NUM_PORTS; i++) begin
                  resp_d[i] = (GW'(i) == grant_q);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d      = ST_IDLE;
            pmem_read_d  = 1'b0;
            pmem_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= LAST_RESET;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         resp_q       <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         pmem_read_q  <= pmem_read_d;
         pmem_write_q <= pmem_write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         resp_q       <= resp_d;
      end
   end

   assign req_resp     = resp_q;
   assign req_rdata    = rdata_q;
   assign pmem_read    = pmem_read_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign busy         = (state_q != ST_IDLE);
   assign grant        = grant_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter
//   Self-checking bench for pmem_arbiter: a 4-port instance driven with
//   directed and randomized requests against a round-robin reference model,
//   plus a 1-port instance for the degenerate pass-through case.
module tb_pmem_arbiter;

   localparam int NP = 4;
   localparam int AW = 16;
   localparam int LW = 128;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- 4-port DUT ----------------
   logic [NP-1:0]    req_read, req_write;
   logic [NP*AW-1:0] req_address;
   logic [NP*LW-1:0] req_wdata;
   logic [NP-1:0]    req_resp;
   logic [LW-1:0]    req_rdata;
   logic             pmem_read, pmem_write;
   logic [AW-1:0]    pmem_address;
   logic [LW-1:0]    pmem_wdata;
   logic             pmem_resp;
   logic [LW-1:0]    pmem_rdata;
   logic             busy;
   logic [1:0]       grant;
   logic [1:0]       dbg_state;

   pmem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk(clk), .rst(rst),
      .req_read(req_read), .req_write(req_write),
      .req_address(req_address), .req_wdata(req_wdata),
      .req_resp(req_resp), .req_rdata(req_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
      .busy(busy), .grant(grant), .dbg_state_o(dbg_state)
   );

   // ---------------- 1-port DUT ----------------
   logic          s_req_read, s_req_write;
   logic [AW-1:0] s_req_address;
   logic [LW-1:0] s_req_wdata;
   logic          s_req_resp;
   logic [LW-1:0] s_req_rdata;
   logic          s_pmem_read, s_pmem_write;
   logic [AW-1:0] s_pmem_address;
   logic [LW-1:0] s_pmem_wdata;
   logic          s_pmem_resp;
   logic [LW-1:0] s_pmem_rdata;
   logic          s_busy;
   logic          s_grant;
   logic [1:0]    s_dbg_state;

   pmem_arbiter #(.NUM_PORTS(1), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut1 (
      .clk(clk), .rst(rst),
      .req_read(s_req_read), .req_write(s_req_write),
      .req_address(s_req_address), .req_wdata(s_req_wdata),
      .req_resp(s_req_resp), .req_rdata(s_req_rdata),
      .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
      .pmem_address(s_pmem_address), .pmem_wdata(s_pmem_wdata),
      .pmem_resp(s_pmem_resp), .pmem_rdata(s_pmem_rdata),
      .busy(s_busy), .grant(s_grant), .dbg_state_o(s_dbg_state)
   );

   // ---------------- scoreboard / model state ----------------
   int            checks = 0;
   int            errors = 0;
   int            last_g = NP - 1;
   logic [LW-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Reference arbitration: first pending port after the last winner,
   // searching circularly.
   function automatic int pick_winner();
      for (int k = 1; k <= NP; k++) begin
         int i;
         i = (last_g + k) % NP;
         if (req_read[i] || req_write[i]) return i;
      end
      return -1;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_req(input int p, input bit rd, input bit wr,
                          input logic [AW-1:0] a, input logic [LW-1:0] d);
      req_read[p]              = rd;
      req_write[p]             = wr;
      req_address[p*AW +: AW]  = a;
      req_wdata[p*LW +: LW]    = d;
   endtask

   task automatic clear_reqs();
      req_read  = '0;
      req_write = '0;
   endtask

   task automatic do_reset();
      clear_reqs();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_g = NP - 1;
   endtask

   // One complete transaction. Called at a negedge with the requests for the
   // coming cycle already set. exp_low: strobe-low negedges expected before
   // the strobe (-1 = don't care). Returns at the negedge of the resp cycle,
   // with the winner's request dropped.
   task automatic do_txn(input int exp_low, input int lat_in,
                         input bit fixed, input logic [LW-1:0] fixed_line, output int w);
      int            n;
      int            lat;
      bit            ew;
      logic [AW-1:0] ea;
      logic [LW-1:0] ed;
      logic [LW-1:0] line;
      logic [NP-1:0] onehot;
      w = pick_winner();
      if (w < 0) begin
         chk("model_pending", 128'(0), 128'(1));
         return;
      end
      ew = req_write[w];
      ea = req_address[w*AW +: AW];
      ed = req_wdata[w*LW +: LW];
      n = 0;
      @(negedge clk);
      chk("resp_clear", 128'(req_resp), 128'(0));
      while (!(pmem_read || pmem_write) && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("strobe_seen", 128'(n < 50), 128'(1));
      if (exp_low >= 0) chk("strobe_gap", 128'(n), 128'(exp_low));
      chk("grant", 128'(grant), 128'(w));
      chk("pmem_write", 128'(pmem_write), 128'(ew));
      chk("pmem_read", 128'(pmem_read), 128'(!ew));
      chk("pmem_address", 128'(pmem_address), 128'(ea));
      if (ew) chk("pmem_wdata", pmem_wdata, ed);
      chk("busy_busy", 128'(busy), 128'(1));
      // The requester scribbles on its address/line while being served.
      req_address[w*AW +: AW] = AW'($urandom);
      req_wdata[w*LW +: LW]   = rand_line();
      lat = (lat_in > 0) ? lat_in : int'($urandom_range(1, 4));
      repeat (lat - 1) begin
         @(negedge clk);
         chk("hold_strobe", 128'({pmem_read, pmem_write}), 128'({!ew, ew}));
         chk("hold_address", 128'(pmem_address), 128'(ea));
         if (ew) chk("hold_wdata", pmem_wdata, ed);
         chk("hold_no_resp", 128'(req_resp), 128'(0));
      end
      line = fixed ? fixed_line : rand_line();
      exp_q.push_back(line);
      pmem_resp  = 1'b1;
      pmem_rdata = line;
      @(negedge clk);
      pmem_resp  = 1'b0;
      pmem_rdata = rand_line();
      onehot     = '0;
      onehot[w]  = 1'b1;
      chk("req_resp", 128'(req_resp), 128'(onehot));
      chk("req_rdata", req_rdata, exp_q.pop_front());
      chk("done_strobes", 128'({pmem_read, pmem_write}), 128'(0));
      chk("done_busy", 128'(busy), 128'(1));
      req_read[w]  = 1'b0;
      req_write[w] = 1'b0;
      last_g       = w;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int            w;
      int            n;
      int            cnt;
      int            first;
      logic [LW-1:0] d;

      req_read      = '0;
      req_write     = '0;
      req_address   = '0;
      req_wdata     = '0;
      pmem_resp     = 1'b0;
      pmem_rdata    = '0;
      s_req_read    = 1'b0;
      s_req_write   = 1'b0;
      s_req_address = '0;
      s_req_wdata   = '0;
      s_pmem_resp   = 1'b0;
      s_pmem_rdata  = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_pmem_read", 128'(pmem_read), 128'(0));
      chk("rst_pmem_write", 128'(pmem_write), 128'(0));
      chk("rst_pmem_address", 128'(pmem_address), 128'(0));
      chk("rst_pmem_wdata", pmem_wdata, 128'(0));
      chk("rst_req_resp", 128'(req_resp), 128'(0));
      chk("rst_req_rdata", req_rdata, 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_grant", 128'(grant), 128'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", 128'(busy), 128'(0));

      // Single read, memory answers after 3 strobe cycles
      set_req(0, 1'b1, 1'b0, 16'h1230, '0);
      do_txn(0, 3, 1'b1, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, w);
      @(negedge clk);
      chk("single_busy_after", 128'(busy), 128'(0));
      chk("single_resp_after", 128'(req_resp), 128'(0));
      chk("single_read_after", 128'(pmem_read), 128'(0));

      // Simultaneous requests from reset: 0 then 1, 2 idle strobe cycles
      do_reset();
      set_req(0, 1'b1, 1'b0, 16'h0100, '0);
      set_req(1, 1'b1, 1'b0, 16'h0200, '0);
      do_txn(0, 0, 1'b0, '0, w);
      do_txn(1, 0, 1'b0, '0, w);

      // Reset mid-transaction, then a stray pmem_resp
      @(negedge clk);
      set_req(2, 1'b1, 1'b0, 16'h0300, '0);
      @(negedge clk);
      chk("midrst_strobe", 128'(pmem_read), 128'(1));
      #2 rst = 1'b1;
      #1;
      chk("midrst_read_drop", 128'(pmem_read), 128'(0));
      chk("midrst_busy_drop", 128'(busy), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      last_g = NP - 1;
      clear_reqs();
      pmem_resp  = 1'b1;
      pmem_rdata = rand_line();
      @(negedge clk);
      pmem_resp = 1'b0;
      chk("stray_no_resp", 128'(req_resp), 128'(0));
      chk("stray_idle", 128'(busy), 128'(0));
      @(negedge clk);
      chk("stray_no_resp2", 128'(req_resp), 128'(0));
      chk("stray_no_strobe", 128'({pmem_read, pmem_write}), 128'(0));

      // Round-robin with every port requesting continuously; first is port 0
      for (int p = 0; p < NP; p++) set_req(p, 1'b1, 1'b0, AW'($urandom), rand_line());
      first = 1;
      for (int t = 0; t < 5; t++) begin
         do_txn(first ? 0 : 1, 0, 1'b0, '0, w);
         first = 0;
         chk("rr_order", 128'(grant), 128'(t % NP));
         set_req(w, 1'b1, 1'b0, AW'($urandom), rand_line());
      end
      clear_reqs();
      @(negedge clk);

      // Write wins over read; line latched despite changes during BUSY
      set_req(1, 1'b1, 1'b1, 16'h8000, {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555});
      do_txn(0, 3, 1'b0, '0, w);
      chk("write_port", 128'(w), 128'(1));
      @(negedge clk);

      // Stray pmem_resp while idle
      pmem_resp = 1'b1;
      @(negedge clk);
      @(negedge clk);
      pmem_resp = 1'b0;
      chk("idle_stray_resp", 128'(req_resp), 128'(0));
      chk("idle_stray_busy", 128'(busy), 128'(0));

      // Randomized traffic against the model
      first = 1;
      for (int t = 0; t < 40; t++) begin
         for (int p = 0; p < NP; p++) begin
            if (!(req_read[p] || req_write[p]) && ($urandom_range(0, 1) == 1)) begin
               int r;
               r = int'($urandom_range(1, 3));
               set_req(p, r[0], r[1], AW'($urandom), rand_line());
            end
         end
         if (req_read == '0 && req_write == '0)
            set_req(int'($urandom_range(0, NP - 1)), 1'b1, 1'b0, AW'($urandom), rand_line());
         do_txn(first ? 0 : 1, 0, 1'b0, '0, w);
         first = 0;
      end
      clear_reqs();
      @(negedge clk);

      // Single-port instance: five back-to-back reads
      s_req_read    = 1'b1;
      s_req_address = 16'h0400;
      cnt = 0;
      for (int t = 0; t < 5; t++) begin
         n = 0;
         @(negedge clk);
         while (!s_pmem_read && n < 20) begin
            n++;
            @(negedge clk);
         end
         chk("sp_strobe", 128'(s_pmem_read), 128'(1));
         chk("sp_gap", 128'(n), 128'((t == 0) ? 0 : 1));
         chk("sp_grant", 128'(s_grant), 128'(0));
         chk("sp_address", 128'(s_pmem_address), 128'(16'h0400));
         d = rand_line();
         s_pmem_resp  = 1'b1;
         s_pmem_rdata = d;
         @(negedge clk);
         s_pmem_resp = 1'b0;
         if (s_req_resp) cnt++;
         chk("sp_rdata", s_req_rdata, d);
         if (t == 4) s_req_read = 1'b0;
      end
      @(negedge clk);
      chk("sp_pulses", 128'(cnt), 128'(5));
      chk("sp_idle", 128'(s_busy), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
